if_stage: RTL and testbench

- Instruction-fetch front end of the RISC-V core; sits directly upstream of decode.
- Generates the PC and issues requests to a synchronous instruction ROM with 1-cycle read latency.
- Buffers returned words in a 2-entry queue and presents {pc, instruction} to decode over a valid/ready handshake.
- Honours branch/jump redirects from execute, and drives the core's debug_pc_out.

---
 rtl/if_stage_if.sv | 50 +++++
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if -- bus bundle between the fetch stage and its neighbours.
//
// Groups the instruction-ROM port, the execute redirect port, the decode
// valid/ready handshake and the debug/perf observation outputs.
//   master : the fetch stage (drives imem_*, id_*, debug_pc_out, perf_*)
//   slave  : the environment (ROM, execute, decode)
//
// Optional macro: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
interface if_stage_if #(
    parameter int unsigned IMEM_AW = 10
);
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               id_valid;
    logic [31:0]        id_pc;
    logic [31:0]        id_inst;
    logic               id_ready;
    logic [31:0]        debug_pc_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_stall_cnt;
`endif

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_inst,
        input  id_ready,
`ifdef IF_PERF_CNT_EN
        output perf_fetch_cnt, perf_stall_cnt,
`endif
        output debug_pc_out
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_inst,
        output id_ready,
`ifdef IF_PERF_CNT_EN
        input  perf_fetch_cnt, perf_stall_cnt,
`endif
        input  debug_pc_out
    );
endinterface

// File: rtl/if_stage.sv
// if_stage -- RISC-V instruction-fetch front end.
//
// Generates the PC, issues reads to a synchronous instruction ROM
// (1-cycle latency), buffers returned words in a 2-entry queue and hands
// {pc, inst} to decode over valid/ready. Execute redirects flush the queue
// and the in-flight response.
//
// Ports:
//   clk  : core clock
//   rst  : synchronous, active-high reset
//   bus  : if_stage_if.master
//          imem_en/imem_addr/imem_rdata   instruction ROM port
//          redirect_valid/redirect_pc     PC change request from execute
//          id_valid/id_pc/id_inst/id_ready decode handshake
//          debug_pc_out                   PC of last accepted instruction
//          perf_fetch_cnt/perf_stall_cnt  (only with IF_PERF_CNT_EN)
//
// Optional macro: IF_PERF_CNT_EN enables the performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_inflight;
    logic [1:0]  r_count;
    logic [31:0] r_head_pc;
    logic [31:0] r_head_inst;
    logic [31:0] r_tail_pc;
    logic [31:0] r_tail_inst;
    logic [31:0] r_debug_pc;

    logic        w_valid;
    logic        w_deq;
    logic        w_accept;
    logic        w_enq;
    logic        w_issue;
    logic [2:0]  w_occ;
    logic        w_unused;

    assign w_valid  = (r_count != 2'd0);
    assign w_deq    = w_valid & bus.id_ready;
    // A handshake coinciding with a redirect is void.
    assign w_accept = w_deq & ~bus.redirect_valid;
    assign w_enq    = r_inflight & ~bus.redirect_valid;
    // Words owned by the stage after this cycle's dequeue: queued + in flight.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_issue  = ~rst & ~bus.redirect_valid & (w_occ < 3'd2);

    assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

    assign bus.imem_en      = w_issue;
    assign bus.imem_addr    = r_pc[IMEM_AW+1:2];
    assign bus.id_valid     = w_valid;
    assign bus.id_pc        = r_head_pc;
    assign bus.id_inst      = r_head_inst;
    assign bus.debug_pc_out = r_debug_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_head_pc   <= '0;
            r_head_inst <= NOP;
            r_tail_pc   <= '0;
            r_tail_inst <= NOP;
            r_debug_pc  <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc       <= {bus.redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            r_inflight <= w_issue;

            if (w_accept) begin
                r_debug_pc <= r_head_pc;
            end

            // Head register is the output register; the tail only holds a
            // second word while decode is stalled.
            case ({w_enq, w_deq})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_pc   <= r_req_pc;
                        r_head_inst <= bus.imem_rdata;
                    end else begin
                        r_tail_pc   <= r_req_pc;
                        r_tail_inst <= bus.imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_pc   <= r_tail_pc;
                        r_head_inst <= r_tail_inst;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head_pc   <= r_tail_pc;
                        r_head_inst <= r_tail_inst;
                        r_tail_pc   <= r_req_pc;
                        r_tail_inst <= bus.imem_rdata;
                    end else begin
                        r_head_pc   <= r_req_pc;
                        r_head_inst <= bus.imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_valid & ~bus.id_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = r_perf_fetch;
    assign bus.perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- self-checking bench for if_stage.
//
// Reference model tracks the instruction stream at the transaction level:
// next PC decode should see, words owned by the stage, cycles since the
// last flush, and the last accepted PC.
module tb_if_stage;
    localparam int unsigned AW  = 10;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_stage_if #(.IMEM_AW(AW)) bus ();

    if_stage #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [1024];
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc;     // PC of next instruction decode should see
    logic [31:0] m_fetch;  // next address the stage should request
    logic [31:0] m_dbg;    // last accepted PC
    int          m_out;    // words issued but not yet accepted or flushed
    int          m_age;    // non-flush cycles since last flush
    int          a_out;    // same, but counted from the DUT's actual issues
    logic [31:0] m_fc;
    logic [31:0] m_sc;
    int          want_fc = -1;
    int          want_sc = -1;

    task automatic model_reset();
        m_pc = RPC; m_fetch = RPC; m_dbg = RPC;
        m_out = 0; a_out = 0; m_age = 0; m_fc = '0; m_sc = '0;
    endtask

    task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
        logic ev, een, deq, act_en;
        @(negedge clk);
        rst = r; bus.redirect_valid = rv; bus.redirect_pc = rp; bus.id_ready = rd;
        #1;
        ev = (m_age >= 2);
        check("id_valid", {31'b0, bus.id_valid}, {31'b0, ev});
        if (ev) begin
            check("id_pc", bus.id_pc, m_pc);
            check("id_inst", bus.id_inst, rom[m_pc[11:2]]);
        end
        deq = ev & rd;
        een = !r && !rv && ((m_out - (deq ? 1 : 0)) < 2);
        act_en = bus.imem_en;
        check("imem_en", {31'b0, act_en}, {31'b0, een});
        if (een) check("imem_addr", {22'b0, bus.imem_addr}, {22'b0, m_fetch[11:2]});
        check("debug_pc_out", bus.debug_pc_out, m_dbg);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", bus.perf_fetch_cnt, m_fc);
        check("perf_stall_cnt", bus.perf_stall_cnt, m_sc);
        if (want_fc >= 0) begin
            check("perf_fetch_10", bus.perf_fetch_cnt, want_fc);
            check("perf_stall_3", bus.perf_stall_cnt, want_sc);
            want_fc = -1; want_sc = -1;
        end
`endif
        // Stage can never own more than two words (queue cannot overflow).
        a_out = a_out + (act_en ? 1 : 0) - ((bus.id_valid && rd && !r && !rv) ? 1 : 0);
        if (r || rv) a_out = 0;
        check("occupancy_le2", {31'b0, (a_out <= 2)}, 32'd1);

        if (ev && !rd) m_sc = m_sc + 32'd1;
        if (r) begin
            model_reset();
        end else if (rv) begin
            m_pc = {rp[31:2], 2'b00}; m_fetch = m_pc; m_out = 0; m_age = 0;
        end else begin
            if (deq) begin
                m_dbg = m_pc; m_pc = m_pc + 32'd4; m_out--; m_fc = m_fc + 32'd1;
            end
            if (een) begin
                m_out++; m_fetch = m_fetch + 32'd4;
            end
            if (m_age < 2) m_age++;
        end
    endtask

    task automatic run(input int n, input logic rd);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rd);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom[k] = 32'h1000_0000 + k;
        rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_inst", bus.id_inst, 32'h0000_0013);
        check("rst_debug_pc", bus.debug_pc_out, RPC);
        check("rst_imem_en", {31'b0, bus.imem_en}, 32'd0);
        model_reset();

        // Reset release, streaming at full rate
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        run(12, 1'b1);

        // Backpressure right after the first valid
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        run(2, 1'b1);
        run(5, 1'b0);
        run(6, 1'b1);

        // Redirect with two words queued
        run(4, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0);
        run(6, 1'b1);

        // Misaligned redirect target
        cycle(1'b0, 1'b1, 32'h0000_0046, 1'b1);
        run(5, 1'b1);

        // Back-to-back redirects: last one wins
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        run(6, 1'b1);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run(6, 1'b1);

        // Reset with a full queue
        run(4, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run(6, 1'b1);

        // Perf scenario: 10 accepted, 3 stalled
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        run(2, 1'b0);
        run(5, 1'b1);
        run(3, 1'b0);
        run(5, 1'b1);
        want_fc = 10; want_sc = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, rv, rd;
            logic [31:0] rp;
            r  = ($urandom_range(0, 127) == 0);
            rv = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       rp = $urandom;
                1:       rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: rp = $urandom & 32'h0000_0FFF;
            endcase
            cycle(r, rv, rp, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
